// File: rtl/approx_mul_pipe.sv
// Three-stage pipelined unsigned multiplier. Each group of four partial-product
// rows can be compressed with an approximate 4:2 cell in the low product columns.
module approx_mul_pipe #(
   parameter int WIDTH       = 8,
   parameter int APPROX_COLS = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic               approx_en,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] product,
   output logic               out_approx
);
   localparam int PW = 2 * WIDTH;
   localparam int NG = WIDTH / 4;

   function automatic logic [PW-1:0] approx_mask();
      logic [PW-1:0] m;
      m = '0;
      for (int c = 0; c < PW; c++) m[c] = (c < APPROX_COLS);
      return m;
   endfunction

   localparam logic [PW-1:0] AMASK = approx_mask();

   logic                        v1_q, v2_q, v3_q;
   logic                        apx1_q, apx2_q, apx3_q;
   logic [WIDTH-1:0][WIDTH-1:0] pp_q, pp_d;
   logic [NG-1:0][PW-1:0]       grp_q, grp_d;
   logic [PW-1:0]               sum_q, sum_d;
   logic                        adv1, adv2, adv3, fire_in;

   // A stage may load when it is empty or its contents move on this cycle.
   assign adv3     = ~v3_q | out_ready;
   assign adv2     = ~v2_q | adv3;
   assign adv1     = ~v1_q | adv2;
   assign in_ready = adv1 & ~rst;
   assign fire_in  = in_valid & in_ready;

   always_comb begin
      pp_d = '0;
      for (int i = 0; i < WIDTH; i++) pp_d[i] = a & {WIDTH{b[i]}};
   end

   for (genvar g = 0; g < NG; g++) begin : g_grp
      logic [3:0][PW-1:0] r;
      logic [PW-1:0]      s, cy, ex, ap;

      for (genvar m = 0; m < 4; m++) begin : g_row
         assign r[m] = {{(PW-WIDTH){1'b0}}, pp_q[4*g+m]} << (4*g+m);
      end

      assign s  = ((r[0] ^ r[1]) ^ (r[2] | r[3])) | (r[2] & r[3]);
      assign cy = ((r[0] ^ r[1]) & (r[2] | r[3])) | (r[0] & r[1]);
      assign ex = r[0] + r[1] + r[2] + r[3];
      // Columns outside the mask keep their four bits and are summed exactly.
      assign ap = (s & AMASK) + ((cy & AMASK) << 1)
                + (r[0] & ~AMASK) + (r[1] & ~AMASK)
                + (r[2] & ~AMASK) + (r[3] & ~AMASK);
      assign grp_d[g] = apx1_q ? ap : ex;
   end

   always_comb begin
      sum_d = '0;
      for (int g = 0; g < NG; g++) sum_d = sum_d + grp_q[g];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1_q   <= 1'b0;
         v2_q   <= 1'b0;
         v3_q   <= 1'b0;
         apx1_q <= 1'b0;
         apx2_q <= 1'b0;
         apx3_q <= 1'b0;
         pp_q   <= '0;
         grp_q  <= '0;
         sum_q  <= '0;
      end else begin
         if (adv1) begin
            v1_q <= fire_in;
            if (fire_in) begin
               pp_q   <= pp_d;
               apx1_q <= approx_en;
            end
         end
         if (adv2) begin
            v2_q <= v1_q;
            if (v1_q) begin
               grp_q  <= grp_d;
               apx2_q <= apx1_q;
            end
         end
         if (adv3) begin
            v3_q <= v2_q;
            if (v2_q) begin
               sum_q  <= sum_d;
               apx3_q <= apx2_q;
            end
         end
      end
   end

   assign out_valid  = v3_q;
   assign product    = sum_q;
   assign out_approx = apx3_q;

endmodule

// File: doc/approx_mul_pipe.md
APPROX_MUL_PIPE -- requirements
Module: approx_mul_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand width; multiple of 4, range 4..16.
REQ-002 SHALL have parameter APPROX_COLS, default 8: product columns 0..APPROX_COLS-1 use approximate compression; range 0..2*WIDTH.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state on rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1 bit: operands and mode presented.
REQ-006 SHALL have port in_ready, output, 1 bit: block accepts operands this cycle.
REQ-007 SHALL have port a, input, WIDTH bits: multiplicand, unsigned.
REQ-008 SHALL have port b, input, WIDTH bits: multiplier, unsigned.
REQ-009 SHALL have port approx_en, input, 1 bit: 1 = approximate product, 0 = exact product; sampled per transaction.
REQ-010 SHALL have port out_valid, output, 1 bit: product is valid.
REQ-011 SHALL have port out_ready, input, 1 bit: consumer accepts the product.
REQ-012 SHALL have port product, output, 2*WIDTH bits: result.
REQ-013 SHALL have port out_approx, output, 1 bit: approx_en of the transaction currently on product.

Function
REQ-014 SHALL define the transfer rule as follows: input transfer when in_valid & in_ready; output transfer when out_valid & out_ready.
REQ-015 SHALL be a 3-stage pipeline. S1 registers the partial-product matrix pp[i][j] = a[j] & b[i] (row i, column i+j). S2 registers the compressed rows. S3 registers the final sum.
REQ-016 SHALL raise out_valid on the 3rd rising edge after an input transfer when not stalled; sustained throughput is 1 transaction per cycle.
REQ-017 SHALL advance each stage when that stage is empty or its successor advances. in_ready = S1 empty or S1 advancing, computed combinationally. No bubbles when out_ready is held at 1.
REQ-018 SHALL hold product, out_approx and out_valid stable while out_valid=1 and out_ready=0, and hold all stage contents likewise; no transaction is dropped or duplicated.
REQ-019 SHALL produce exactly a*b when approx_en=0.
REQ-020 SHALL compute as follows when approx_en=1. Rows are grouped 4k..4k+3, giving inputs q1..q4 in that order. For each group and each column c < APPROX_COLS, the approximate compressor produces apx_sum = ((q1^q2)^(q3|q4)) | (q3&q4) at weight c and apx_carry = ((q1^q2)&(q3|q4)) | (q1&q2) at weight c+1. Columns >= APPROX_COLS keep their four bits unchanged. The product is the exact sum of all resulting bits, modulo 2^(2*WIDTH).
REQ-021 SHALL yield a*b exactly when APPROX_COLS = 0, regardless of approx_en.
REQ-022 SHALL carry approx_en through the pipeline alongside its operands; the mode SHALL be freely mixable between consecutive transactions.
REQ-023 SHALL ignore a, b and approx_en when no input transfer occurs.
REQ-024 SHALL, on simultaneous input and output transfer with all stages full, advance all stages in that cycle and keep in_ready=1.

Reset
REQ-025 SHALL, while rst=1, clear all stage valid flags immediately without waiting for clk, forcing out_valid=0, product=0, out_approx=0 and in_ready=0.
REQ-026 SHALL set in_ready=1 on the first cycle after rst deasserts.
REQ-027 SHALL discard all in-flight transactions when rst asserts mid-operation; no product from before reset appears afterwards.

Verification
REQ-028 SHALL pass this scenario (WIDTH=8, APPROX_COLS=8, out_ready=1): a=255, b=255, approx_en=0 -> product=65025, out_approx=0, 3 cycles after transfer.
REQ-029 SHALL pass these scenarios (same configuration): a=3, b=12, approx_en=1 -> product=28; a=3, b=12, approx_en=0 -> product=36; a=1, b=1, approx_en=1 -> product=1.
REQ-030 SHALL pass this scenario: back-to-back stream of 16 random pairs with alternating approx_en and out_ready=1 -> 16 consecutive out_valid cycles, each matching the REQ-019/REQ-020 model in order.
REQ-031 SHALL pass this scenario: out_ready=0 for 5 cycles while in_valid=1 -> in_ready=0 after 3 accepted transactions, product held constant; out_ready=1 -> the 3 results emerge in order.
REQ-032 SHALL pass this scenario: rst pulsed asynchronously between clock edges with 2 transactions in flight -> out_valid=0 immediately, and no stale output after release.
REQ-033 SHALL pass this scenario: APPROX_COLS=0 with 1000 random operands and approx_en=1 -> product equals a*b for every transaction.
